mem_port_arbiter: RTL and testbench

Shares the single-port main memory between the fetch stage (instruction reads) and the memory stage (data loads/stores) of the pipelined CPU. It issues at most one memory command per cycle and routes the one-cycle-latency read data back to the requester that issued it. Arbitration is data-priority with a bounded-starvation override for fetch. It also produces the fetch stall that the fetch stage ORs into its existing stall.

---
 rtl/mem_port_arbiter.sv | 82 ++++++++
 tb/tb_mem_port_arbiter.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter between instruction fetch and data access.
// Data has priority; fetch wins after MAX_STARVE lost contention cycles.
module mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MAX_STARVE = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic              fetch_gnt,
  output logic              fetch_rvalid,
  output logic [DATA_W-1:0] fetch_rdata,
  output logic              fetch_stall,
  input  logic              data_req,
  input  logic              data_we,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [DATA_W-1:0] data_wdata,
  output logic              data_gnt,
  output logic              data_rvalid,
  output logic [DATA_W-1:0] data_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [3:0] STARVE_MAX = 4'(MAX_STARVE);

  logic [3:0] starve_cnt;
  logic       rd_pending;
  logic       rd_owner;   // 0 = fetch, 1 = data
  logic       contend;

  always_comb begin
    contend   = fetch_req & data_req;
    // rst low suppresses every grant, so nothing reaches memory in reset
    fetch_gnt = rst & fetch_req & (~data_req | (starve_cnt == STARVE_MAX));
    data_gnt  = rst & data_req & ~fetch_gnt;

    mem_en    = fetch_gnt | data_gnt;
    mem_we    = data_gnt & data_we;
    mem_addr  = '0;
    if (fetch_gnt)     mem_addr = fetch_addr;
    else if (data_gnt) mem_addr = data_addr;
    mem_wdata = mem_we ? data_wdata : '0;

    fetch_stall  = rst & fetch_req & ~fetch_gnt;

    fetch_rvalid = rst & rd_pending & ~rd_owner;
    data_rvalid  = rst & rd_pending &  rd_owner;
    fetch_rdata  = fetch_rvalid ? mem_rdata : '0;
    data_rdata   = data_rvalid  ? mem_rdata : '0;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      starve_cnt <= '0;
      rd_pending <= 1'b0;
      rd_owner   <= 1'b0;
    end else begin
      if (fetch_gnt)
        starve_cnt <= '0;
      else if (contend && data_gnt && starve_cnt != STARVE_MAX)
        starve_cnt <= starve_cnt + 4'd1;

      // Tag lives exactly one cycle: any non-read cycle clears it
      if (fetch_gnt) begin
        rd_pending <= 1'b1;
        rd_owner   <= 1'b0;
      end else if (data_gnt) begin
        rd_pending <= ~data_we;
        rd_owner   <= 1'b1;
      end else begin
        rd_pending <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a 16-word one-cycle-latency memory model.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        fetch_req, fetch_gnt, fetch_rvalid, fetch_stall;
  logic [31:0] fetch_addr, fetch_rdata;
  logic        data_req, data_we, data_gnt, data_rvalid;
  logic [31:0] data_addr, data_wdata, data_rdata;
  logic        mem_en, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  logic [31:0] mem [0:15];
  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_STARVE(3)) dut (
    .clk(clk), .rst(rst),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_gnt(fetch_gnt),
    .fetch_rvalid(fetch_rvalid), .fetch_rdata(fetch_rdata), .fetch_stall(fetch_stall),
    .data_req(data_req), .data_we(data_we), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_gnt(data_gnt), .data_rvalid(data_rvalid),
    .data_rdata(data_rdata), .mem_en(mem_en), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // Memory preloads mem[n] = 0x100+n while in reset
  always @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 16; i++) mem[i] <= 32'h100 + 32'(i);
      mem_rdata <= '0;
    end else if (mem_en) begin
      if (mem_we) mem[mem_addr[3:0]] <= mem_wdata;
      else        mem_rdata <= mem[mem_addr[3:0]];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Drive one cycle's inputs at negedge, then settle before checks
  task automatic cyc(input logic r, input logic fr, input logic [31:0] fa,
                     input logic dr, input logic dwe, input logic [31:0] da,
                     input logic [31:0] dwd);
    @(negedge clk);
    rst = r; fetch_req = fr; fetch_addr = fa;
    data_req = dr; data_we = dwe; data_addr = da; data_wdata = dwd;
    #1;
  endtask

  initial begin
    rst = 1'b0; fetch_req = 1'b0; fetch_addr = '0;
    data_req = 1'b0; data_we = 1'b0; data_addr = '0; data_wdata = '0;

    // Reset with both requests high: everything suppressed
    cyc(0, 1, 1, 1, 0, 2, 0);
    cyc(0, 1, 1, 1, 0, 2, 0);
    chk1("rst_fgnt", fetch_gnt, 0);
    chk1("rst_dgnt", data_gnt, 0);
    chk1("rst_men", mem_en, 0);
    chk1("rst_stall", fetch_stall, 0);
    chk("rst_maddr", mem_addr, 0);
    chk("rst_starve", {28'd0, dut.starve_cnt}, 0);

    // Fetch-only stream 0,1,2
    cyc(1, 1, 0, 0, 0, 0, 0);
    chk1("f0_gnt", fetch_gnt, 1); chk1("f0_men", mem_en, 1); chk1("f0_rv", fetch_rvalid, 0);
    cyc(1, 1, 1, 0, 0, 0, 0);
    chk1("f1_gnt", fetch_gnt, 1); chk1("f1_rv", fetch_rvalid, 1); chk("f1_rd", fetch_rdata, 32'h100);
    chk1("f1_drv", data_rvalid, 0); chk("f1_maddr", mem_addr, 1);
    cyc(1, 1, 2, 0, 0, 0, 0);
    chk1("f2_gnt", fetch_gnt, 1); chk("f2_rd", fetch_rdata, 32'h101); chk1("f2_drv", data_rvalid, 0);
    cyc(1, 0, 0, 0, 0, 0, 0);
    chk1("f3_rv", fetch_rvalid, 1); chk("f3_rd", fetch_rdata, 32'h102);
    chk1("f3_men", mem_en, 0); chk("f3_maddr", mem_addr, 0); chk1("f3_drv", data_rvalid, 0);
    cyc(1, 0, 0, 0, 0, 0, 0);
    chk1("f4_rv", fetch_rvalid, 0); chk("f4_rd", fetch_rdata, 0);

    // Single contention: data load 8 beats fetch 4
    cyc(1, 1, 4, 1, 0, 8, 0);
    chk1("c0_dgnt", data_gnt, 1); chk1("c0_fgnt", fetch_gnt, 0);
    chk1("c0_stall", fetch_stall, 1); chk("c0_maddr", mem_addr, 8); chk1("c0_mwe", mem_we, 0);
    cyc(1, 1, 4, 0, 0, 0, 0);
    chk1("c1_fgnt", fetch_gnt, 1); chk1("c1_stall", fetch_stall, 0);
    chk1("c1_drv", data_rvalid, 1); chk("c1_drd", data_rdata, 32'h108); chk1("c1_frv", fetch_rvalid, 0);
    cyc(1, 0, 0, 0, 0, 0, 0);
    chk1("c2_frv", fetch_rvalid, 1); chk("c2_frd", fetch_rdata, 32'h104);
    chk1("c2_drv", data_rvalid, 0); chk("c2_starve", {28'd0, dut.starve_cnt}, 0);

    // Starvation: fetch held at 9, data loads 1..4
    cyc(1, 1, 9, 1, 0, 1, 0);
    chk1("s0_dgnt", data_gnt, 1); chk1("s0_stall", fetch_stall, 1);
    cyc(1, 1, 9, 1, 0, 2, 0);
    chk1("s1_dgnt", data_gnt, 1); chk("s1_drd", data_rdata, 32'h101);
    cyc(1, 1, 9, 1, 0, 3, 0);
    chk1("s2_dgnt", data_gnt, 1); chk1("s2_stall", fetch_stall, 1); chk("s2_drd", data_rdata, 32'h102);
    cyc(1, 1, 9, 1, 0, 4, 0);
    chk("s3_starve", {28'd0, dut.starve_cnt}, 3);
    chk1("s3_fgnt", fetch_gnt, 1); chk1("s3_dgnt", data_gnt, 0); chk1("s3_stall", fetch_stall, 0);
    chk("s3_maddr", mem_addr, 9); chk("s3_drd", data_rdata, 32'h103);
    cyc(1, 1, 9, 1, 0, 4, 0);
    chk("s4_starve", {28'd0, dut.starve_cnt}, 0);
    chk1("s4_dgnt", data_gnt, 1); chk1("s4_frv", fetch_rvalid, 1);
    chk("s4_frd", fetch_rdata, 32'h109); chk1("s4_drv", data_rvalid, 0);
    cyc(1, 0, 0, 0, 0, 0, 0);
    chk("s5_drd", data_rdata, 32'h104);
    cyc(1, 0, 0, 0, 0, 0, 0);
    chk("s6_starve_hold", {28'd0, dut.starve_cnt}, 1);

    // Store then fetch of the same address
    cyc(1, 0, 0, 1, 1, 5, 32'hDEADBEEF);
    chk1("w0_dgnt", data_gnt, 1); chk1("w0_mwe", mem_we, 1);
    chk("w0_wdata", mem_wdata, 32'hDEADBEEF); chk("w0_maddr", mem_addr, 5);
    cyc(1, 1, 5, 0, 0, 0, 0);
    chk1("w1_fgnt", fetch_gnt, 1); chk1("w1_mwe", mem_we, 0);
    chk1("w1_drv", data_rvalid, 0); chk1("w1_frv", fetch_rvalid, 0);
    cyc(1, 0, 0, 0, 0, 0, 0);
    chk1("w2_frv", fetch_rvalid, 1); chk("w2_frd", fetch_rdata, 32'hDEADBEEF);
    chk1("w2_drv", data_rvalid, 0);

    // Reset the cycle after a read grant: rvalid dropped
    cyc(1, 1, 2, 1, 0, 3, 0);
    chk1("r0_dgnt", data_gnt, 1);
    cyc(0, 1, 2, 1, 0, 3, 0);
    chk1("r1_drv", data_rvalid, 0); chk("r1_drd", data_rdata, 0);
    chk1("r1_fgnt", fetch_gnt, 0); chk1("r1_dgnt", data_gnt, 0);
    chk1("r1_men", mem_en, 0); chk1("r1_stall", fetch_stall, 0);
    cyc(1, 0, 0, 0, 0, 0, 0);
    chk1("r2_drv", data_rvalid, 0); chk1("r2_frv", fetch_rvalid, 0);
    chk("r2_starve", {28'd0, dut.starve_cnt}, 0);
    cyc(1, 1, 6, 1, 0, 7, 0);
    chk1("r3_dgnt", data_gnt, 1); chk1("r3_stall", fetch_stall, 1);
    cyc(1, 1, 6, 0, 0, 0, 0);
    chk1("r4_fgnt", fetch_gnt, 1); chk("r4_drd", data_rdata, 32'h107);
    cyc(1, 0, 0, 0, 0, 0, 0);
    chk("r5_frd", fetch_rdata, 32'h106); chk1("r5_drv", data_rvalid, 0);

    // Alternating fetch / data loads
    cyc(1, 1, 10, 0, 0, 0, 0);
    chk1("a0_fgnt", fetch_gnt, 1); chk1("a0_stall", fetch_stall, 0);
    cyc(1, 0, 0, 1, 0, 11, 0);
    chk1("a1_dgnt", data_gnt, 1); chk("a1_frd", fetch_rdata, 32'h10A); chk1("a1_drv", data_rvalid, 0);
    cyc(1, 1, 12, 0, 0, 0, 0);
    chk1("a2_fgnt", fetch_gnt, 1); chk("a2_drd", data_rdata, 32'h10B); chk1("a2_frv", fetch_rvalid, 0);
    cyc(1, 0, 0, 1, 0, 13, 0);
    chk1("a3_dgnt", data_gnt, 1); chk("a3_frd", fetch_rdata, 32'h10C); chk1("a3_drv", data_rvalid, 0);
    cyc(1, 0, 0, 0, 0, 0, 0);
    chk("a4_drd", data_rdata, 32'h10D); chk1("a4_frv", fetch_rvalid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
